// File: rtl/mac_act_pipe.sv
// Multi-lane signed MAC with bias, Q-format rescale, saturation and an LFSR-scaled activation.
// Vectors arrive as beats; each finished vector produces one registered result.
module mac_act_pipe #(
   parameter int          NLANE = 8,
   parameter int          DW    = 16,
   parameter int          FRAC  = 8,
   parameter int          ACC_W = 2*DW+8,
   parameter logic [7:0]  SEED  = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_last,
   input  logic [NLANE*DW-1:0]   a_data,
   input  logic [NLANE*DW-1:0]   w_data,
   input  logic [DW-1:0]         bias,
   input  logic [1:0]            op_mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DW-1:0]         out_data,
   output logic                  out_sat
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, FIN = 2'd2, OUT = 2'd3} state_t;

   localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

   function automatic logic [7:0] lfsr_next(input logic [7:0] x);
      return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
   endfunction

   state_t                   state_r, state_s;
   logic                     in_ready_r, out_valid_r, out_sat_r;
   logic [DW-1:0]            out_data_r;
   logic signed [ACC_W-1:0]  acc_r;
   logic signed [DW-1:0]     bias_r;
   logic [1:0]               mode_r;
   logic [7:0]               lfsr_r;

   logic                     accept_s, hs_s, acc_load_s, acc_add_s, fin_s;
   logic signed [ACC_W-1:0]  beat_sum_s, biased_s, shifted_s;
   logic signed [DW-1:0]     clamped_s, relu_s, mul_in_s, scaled_s, result_s;
   logic signed [DW+8:0]     scale_prod_s, scale_sh_s;
   logic                     sat_s;

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_sat   = out_sat_r;

   // Sum of full-precision lane products, sign-extended into the accumulator width
   always_comb begin : beat_sum_p
      logic signed [DW-1:0]   a_v, w_v;
      logic signed [2*DW-1:0] prod_v;
      beat_sum_s = '0;
      for (int i = 0; i < NLANE; i++) begin
         a_v        = a_data[i*DW +: DW];
         w_v        = w_data[i*DW +: DW];
         prod_v     = (2*DW)'(a_v) * (2*DW)'(w_v);
         beat_sum_s = beat_sum_s + ACC_W'(prod_v);
      end
   end

   // Bias, floor rescale, clamp and mode-dependent activation
   always_comb begin
      biased_s  = acc_r + (ACC_W'(bias_r) <<< FRAC);
      shifted_s = biased_s >>> FRAC;
      if (shifted_s > MAX_V) begin
         clamped_s = MAX_V[DW-1:0];
         sat_s     = 1'b1;
      end else if (shifted_s < MIN_V) begin
         clamped_s = MIN_V[DW-1:0];
         sat_s     = 1'b1;
      end else begin
         clamped_s = DW'(shifted_s);
         sat_s     = 1'b0;
      end
      relu_s       = clamped_s[DW-1] ? '0 : clamped_s;
      mul_in_s     = (mode_r == 2'd3) ? clamped_s : relu_s;
      scale_prod_s = (DW+9)'(mul_in_s) * (DW+9)'($signed({1'b0, lfsr_r}));
      scale_sh_s   = scale_prod_s >>> 8;
      scaled_s     = DW'(scale_sh_s);
      case (mode_r)
         2'd0:    result_s = clamped_s;
         2'd1:    result_s = relu_s;
         2'd2:    result_s = scaled_s;
         2'd3:    result_s = scaled_s;
         default: result_s = clamped_s;
      endcase
   end

   // State register; in_ready is registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         in_ready_r <= 1'b0;
      end else begin
         state_r    <= state_s;
         in_ready_r <= (state_s == IDLE) || (state_s == ACC);
      end
   end

   // Next-state logic; clr overrides everything except rst
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    if (accept_s) state_s = in_last ? FIN : ACC; else state_s = IDLE;
         ACC:     if (accept_s && in_last) state_s = FIN; else state_s = ACC;
         FIN:     state_s = OUT;
         OUT:     if (hs_s) state_s = IDLE; else state_s = OUT;
         default: state_s = IDLE;
      endcase
      if (clr) state_s = IDLE;
      else     state_s = state_s;
   end

   // FSM control strobes
   always_comb begin
      accept_s   = in_valid && in_ready_r && !clr;
      hs_s       = out_valid_r && out_ready && !clr;
      acc_load_s = accept_s && (state_r == IDLE);
      acc_add_s  = accept_s && (state_r == ACC);
      fin_s      = (state_r == FIN) && !clr;
   end

   // Accumulator, latched vector controls and registered result
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_r       <= '0;
         bias_r      <= '0;
         mode_r      <= 2'd0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_sat_r   <= 1'b0;
      end else if (clr) begin
         acc_r       <= '0;
         out_valid_r <= 1'b0;
      end else begin
         if (acc_load_s) begin
            acc_r  <= beat_sum_s;
            bias_r <= bias;
            mode_r <= op_mode;
         end else if (acc_add_s) begin
            acc_r <= acc_r + beat_sum_s;
         end
         if (fin_s) begin
            out_data_r  <= result_s;
            out_sat_r   <= sat_s;
            out_valid_r <= 1'b1;
         end else if (hs_s) begin
            out_valid_r <= 1'b0;
         end
      end
   end

   // Scale LFSR steps once per delivered result
   always_ff @(posedge clk) begin
      if (rst)       lfsr_r <= SEED;
      else if (hs_s) lfsr_r <= lfsr_next(lfsr_r);
      else           lfsr_r <= lfsr_r;
   end

endmodule

// File: tb/tb_mac_act_pipe.sv
// Directed, table-driven bench for mac_act_pipe with hand-computed results,
// plus sequences for back-pressure, clr and reset in mid-flight.
module tb_mac_act_pipe;

   logic         clk = 1'b0;
   logic         rst, clr, in_valid, in_ready, in_last, out_valid, out_ready, out_sat;
   logic [127:0] a_data, w_data;
   logic [15:0]  bias, out_data;
   logic [1:0]   op_mode;

   int n_applied = 0;
   int n_fail    = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] a0;
      logic [15:0] w;
      logic [15:0] bias;
      logic [1:0]  mode;
      int          nbeats;
      logic [15:0] exp_data;
      logic        exp_sat;
   } vec_t;

   vec_t tbl[13];

   mac_act_pipe dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .a_data(a_data), .w_data(w_data), .bias(bias), .op_mode(op_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sat(out_sat)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic set_lanes(input logic [15:0] a, input logic [15:0] a0, input logic [15:0] w);
      for (int i = 0; i < 8; i++) begin
         a_data[i*16 +: 16] = (i == 0) ? a0 : a;
         w_data[i*16 +: 16] = w;
      end
   endtask

   // Drives every beat, then samples the result two edges after the last accept
   task automatic send_vector(input vec_t v, input string name);
      for (int b = 0; b < v.nbeats; b++) begin
         set_lanes(v.a, v.a0, v.w);
         bias     = (b == 0) ? v.bias : 16'h7777;
         op_mode  = (b == 0) ? v.mode : ~v.mode;
         in_last  = (b == v.nbeats - 1);
         in_valid = 1'b1;
         for (int k = 0; k < 20 && !in_ready; k++) begin
            @(posedge clk); #1;
         end
         check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      check({name, " out_valid"}, {31'd0, out_valid}, 32'd1);
      check({name, " data"},      {16'd0, out_data},  {16'd0, v.exp_data});
      check({name, " sat"},       {31'd0, out_sat},   {31'd0, v.exp_sat});
   endtask

   task automatic finish_out(input string name);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, " valid drop"}, {31'd0, out_valid}, 32'd0);
      check({name, " ready back"}, {31'd0, in_ready},  32'd1);
   endtask

   initial begin
      vec_t v042;
      // a, a0, w, bias, mode, beats, expected data, expected sat
      tbl[0]  = '{16'h0100, 16'h0100, 16'h0200, 16'h0080, 2'd2, 1, 16'h0AA2, 1'b0};
      tbl[1]  = '{16'h0100, 16'h0100, 16'h0200, 16'h0080, 2'd2, 1, 16'h0F15, 1'b0};
      tbl[2]  = '{16'h0100, 16'h0100, 16'h0200, 16'h0080, 2'd0, 1, 16'h1080, 1'b0};
      tbl[3]  = '{16'h0100, 16'h0100, 16'hFF00, 16'h0000, 2'd0, 1, 16'hF800, 1'b0};
      tbl[4]  = '{16'h0100, 16'h0100, 16'hFF00, 16'h0000, 2'd1, 1, 16'h0000, 1'b0};
      tbl[5]  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 2'd0, 2, 16'h7FFF, 1'b1};
      tbl[6]  = '{16'h8000, 16'h8000, 16'h7FFF, 16'h0000, 2'd0, 1, 16'h8000, 1'b1};
      tbl[7]  = '{16'h0100, 16'h0100, 16'hFF00, 16'hFFFF, 2'd3, 1, 16'hFECF, 1'b0};
      tbl[8]  = '{16'h0100, 16'h0100, 16'hFF00, 16'hFFFF, 2'd2, 1, 16'h0000, 1'b0};
      tbl[9]  = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0000, 2'd0, 1, 16'hFFFF, 1'b0};
      tbl[10] = '{16'h0100, 16'h0300, 16'h0100, 16'h0100, 2'd0, 3, 16'h1F00, 1'b0};
      tbl[11] = '{16'h0100, 16'h0100, 16'h0200, 16'h0080, 2'd3, 1, 16'h0738, 1'b0};
      tbl[12] = '{16'h8000, 16'h8000, 16'h7FFF, 16'h0000, 2'd1, 1, 16'h0000, 1'b1};
      v042    = tbl[2];

      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      a_data = '0; w_data = '0; bias = '0; op_mode = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset out_data",  {16'd0, out_data},  32'd0);
      check("reset out_sat",   {31'd0, out_sat},   32'd0);
      check("reset in_ready",  {31'd0, in_ready},  32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post-reset in_ready", {31'd0, in_ready}, 32'd1);

      // LFSR steps A5,EA,75,82,41,98,4C,26,13,B1,E0,70,38 across the table
      for (int i = 0; i < 13; i++) begin
         send_vector(tbl[i], $sformatf("v%0d", i));
         finish_out($sformatf("v%0d", i));
      end

      // Back-pressure: result held, offered beats ignored
      send_vector(v042, "hold");
      set_lanes(16'h7FFF, 16'h7FFF, 16'h7FFF);
      in_valid = 1'b1; in_last = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("hold c%0d valid", c), {31'd0, out_valid}, 32'd1);
         check($sformatf("hold c%0d data", c),  {16'd0, out_data},  32'h1080);
         check($sformatf("hold c%0d sat", c),   {31'd0, out_sat},   32'd0);
         check($sformatf("hold c%0d ready", c), {31'd0, in_ready},  32'd0);
      end
      in_valid = 1'b0; in_last = 1'b0;
      finish_out("hold");
      send_vector(tbl[3], "after hold");
      finish_out("after hold");

      // clr after 2 of 3 beats; the beat offered alongside clr is dropped
      set_lanes(16'h7FFF, 16'h7FFF, 16'h7FFF);
      bias = 16'h0000; op_mode = 2'd0; in_last = 1'b0; in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      clr = 1'b1; in_last = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      check("clr in_ready", {31'd0, in_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1;
      check("clr no output", {31'd0, out_valid}, 32'd0);
      send_vector(v042, "after clr");
      finish_out("after clr");

      // rst while a result is waiting
      send_vector(v042, "rst in out");
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst in out valid", {31'd0, out_valid}, 32'd0);
      check("rst in out data",  {16'd0, out_data},  32'd0);
      check("rst in out ready", {31'd0, in_ready},  32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      send_vector(tbl[0], "seed after rst");
      finish_out("seed after rst");

      // clr while a result is waiting: no handshake, so the LFSR stays at EA
      send_vector(v042, "clr in out");
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      check("clr in out valid", {31'd0, out_valid}, 32'd0);
      check("clr in out ready", {31'd0, in_ready},  32'd1);
      send_vector(tbl[1], "lfsr after clr");
      finish_out("lfsr after clr");

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
      $finish;
   end

endmodule
